// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer : command-side controller for the 16-bit ALU result mux.
// Optional feature macro: ALU_SEQ_CHAIN_EN (accumulator-chained operand A).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int WIDTH       = 16,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic             cmd_chain,
`endif
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [11:0]      sel,
  input  logic [WIDTH-1:0] res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] acc
);

  localparam logic [3:0] c_NUM_OPS  = 4'd12;
  localparam logic [3:0] c_CNT_INIT = 4'(EXEC_CYCLES - 1);
  localparam int         c_SEL_CLR  = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [11:0]      r_sel;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic             w_done;
  logic             w_release;
  logic [11:0]      w_sel_enc;
  logic [WIDTH-1:0] w_op_a_src;

  // Illegal opcodes encode to an all-zero select; capture uses that as the error flag.
  assign w_sel_enc = (cmd_op < c_NUM_OPS) ? (12'b1 << cmd_op) : 12'b0;

`ifdef ALU_SEQ_CHAIN_EN
  assign w_op_a_src = cmd_chain ? r_acc : cmd_a;
`else
  assign w_op_a_src = cmd_a;
`endif

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign w_done    = (r_state == S_EXEC) && (r_cnt == 4'd0);
  assign w_release = (r_state == S_RESP) && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_sel      <= 12'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_acc      <= '0;
    end else begin
      if (w_accept) begin
        r_op_a <= w_op_a_src;
        r_op_b <= cmd_b;
        r_sel  <= w_sel_enc;
        r_cnt  <= c_CNT_INIT;
      end else if (w_done) begin
        if (r_sel == 12'b0) begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
        end else begin
          r_rsp_data <= res;
          r_rsp_err  <= 1'b0;
          r_acc      <= r_sel[c_SEL_CLR] ? '0 : res;
        end
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (w_release) begin
        r_sel <= 12'b0;
      end
    end
  end

  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign sel      = r_sel;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;
  assign acc      = r_acc;

endmodule

`default_nettype wire
